// File: rtl/store_sequencer_if.sv
// store_sequencer_if
//   Data-memory write port between store_sequencer (master) and memory (slave).
//   MemReq    : write transaction valid (master -> slave)
//   MemReady  : memory accepts when MemReq & MemReady (slave -> master)
//   MemAddr   : word-aligned write address
//   MemByteEn : byte-lane write mask, bit i enables lane i
//   MemWData  : lane-aligned write data
interface store_sequencer_if;
  logic        MemReq;
  logic        MemReady;
  logic [31:0] MemAddr;
  logic [3:0]  MemByteEn;
  logic [31:0] MemWData;

  modport master (
    output MemReq,
    output MemAddr,
    output MemByteEn,
    output MemWData,
    input  MemReady
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    input  MemByteEn,
    input  MemWData,
    output MemReady
  );
endinterface

// File: rtl/store_sequencer.sv
// store_sequencer
//   Store-path controller between the Memory stage and the data-memory write
//   port. Captures SB/SH/SW, builds the byte mask and lane-aligned data, and
//   issues one or two word-aligned writes, stalling the pipeline until the
//   final access is accepted.
//
// Configuration macro: MISALIGNED_SPLIT_EN
//   defined   : word-crossing stores are split into LO and HI accesses
//   undefined : word-crossing stores are rejected with MisalignFaultM
//
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   MemWriteM       store request from Memory stage
//   Funct3M         store width (000 SB, 001 SH, else SW)
//   AddrM           byte address of the store
//   WriteDataM      LSB-justified store data
//   StallM          hold pipeline (combinational)
//   MisalignFaultM  misaligned store rejected (combinational)
//   mem             write-port interface (master side)
module store_sequencer (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [31:0]           AddrM,
  input  logic [31:0]           WriteDataM,
  output logic                  StallM,
  output logic                  MisalignFaultM,
  store_sequencer_if.master     mem
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_dhi;
  logic [3:0]  r_mhi;
  logic        r_split;

  logic [3:0]  w_base;
  logic [7:0]  w_mask;
  logic [63:0] w_data;
  logic        w_cross;
  logic        w_split;
  logic        w_reject;
  logic        w_idle;

  always_comb begin
    case (Funct3M)
      3'b000:  w_base = 4'b0001;
      3'b001:  w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
    w_mask  = {4'b0000, w_base} << AddrM[1:0];
    w_data  = {32'b0, WriteDataM} << {AddrM[1:0], 3'b000};
    // Any mask bit past lane 3 means the store crosses into the next word.
    w_cross = |w_mask[7:4];
`ifdef MISALIGNED_SPLIT_EN
    w_split  = w_cross;
    w_reject = 1'b0;
`else
    w_split  = 1'b0;
    w_reject = w_cross;
`endif
    w_idle         = (r_state == IDLE);
    MisalignFaultM = w_idle & MemWriteM & w_reject;
    StallM         = (w_idle & MemWriteM & ~w_reject)
                   | ((r_state == LO) & ~(mem.MemReady & ~r_split))
                   | ((r_state == HI) & ~mem.MemReady);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_dhi   <= '0;
      r_mhi   <= '0;
      r_split <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (MemWriteM && !w_reject) begin
            // Output registers are loaded with the LO beat directly; the HI
            // beat is parked in r_dhi/r_mhi until LO is accepted.
            r_state <= LO;
            r_req   <= 1'b1;
            r_addr  <= {AddrM[31:2], 2'b00};
            r_be    <= w_mask[3:0];
            r_wdata <= w_data[31:0];
            r_mhi   <= w_mask[7:4];
            r_dhi   <= w_data[63:32];
            r_split <= w_split;
          end
        end
        LO: begin
          if (mem.MemReady) begin
            if (r_split) begin
              r_state <= HI;
              r_addr  <= r_addr + 32'd4;
              r_be    <= r_mhi;
              r_wdata <= r_dhi;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
              r_be    <= '0;
            end
          end
        end
        HI: begin
          if (mem.MemReady) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_be    <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_be    <= '0;
        end
      endcase
    end
  end

  assign mem.MemReq    = r_req;
  assign mem.MemAddr   = r_addr;
  assign mem.MemByteEn = r_be;
  assign mem.MemWData  = r_wdata;

endmodule

// File: tb/tb_store_sequencer.sv
module tb_store_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic        MisalignFaultM;

  store_sequencer_if mem ();

  store_sequencer dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .MemWriteM      (MemWriteM),
    .Funct3M        (Funct3M),
    .AddrM          (AddrM),
    .WriteDataM     (WriteDataM),
    .StallM         (StallM),
    .MisalignFaultM (MisalignFaultM),
    .mem            (mem.master)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rej;
    logic        split;
    logic [31:0] lo_a;
    logic [3:0]  lo_be;
    logic [31:0] lo_d;
    logic [31:0] hi_a;
    logic [3:0]  hi_be;
    logic [31:0] hi_d;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic rej, input logic split,
                              input logic [31:0] lo_a, input logic [3:0] lo_be,
                              input logic [31:0] lo_d, input logic [31:0] hi_a,
                              input logic [3:0] hi_be, input logic [31:0] hi_d);
    vec_t v;
    v.f3 = f3; v.addr = addr; v.data = data; v.rej = rej; v.split = split;
    v.lo_a = lo_a; v.lo_be = lo_be; v.lo_d = lo_d;
    v.hi_a = hi_a; v.hi_be = hi_be; v.hi_d = hi_d;
    return v;
  endfunction

  vec_t tbl[9];
  vec_t v;

  initial begin
    // Fully worked expectations; crossing stores depend on the build option.
    tbl[0] = mk(3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 0);
    tbl[1] = mk(3'b000, 32'h203, 32'h000000AB, 0, 0, 32'h200, 4'b1000, 32'hAB000000, 0, 0, 0);
    tbl[2] = mk(3'b001, 32'h021, 32'h0000BEEF, 0, 0, 32'h020, 4'b0110, 32'h00BEEF00, 0, 0, 0);
    tbl[3] = mk(3'b000, 32'h041, 32'hFFFFFF5A, 0, 0, 32'h040, 4'b0010, 32'hFFFF5A00, 0, 0, 0);
    tbl[4] = mk(3'b111, 32'h080, 32'hCAFEF00D, 0, 0, 32'h080, 4'b1111, 32'hCAFEF00D, 0, 0, 0);
    tbl[5] = mk(3'b001, 32'h012, 32'h000000A5, 0, 0, 32'h010, 4'b1100, 32'h00A50000, 0, 0, 0);
`ifdef MISALIGNED_SPLIT_EN
    tbl[6] = mk(3'b001, 32'h00F, 32'h00001234, 0, 1, 32'h00C, 4'b1000, 32'h34000000,
                32'h010, 4'b0001, 32'h00000012);
    tbl[7] = mk(3'b010, 32'h102, 32'h11223344, 0, 1, 32'h100, 4'b1100, 32'h33440000,
                32'h104, 4'b0011, 32'h00001122);
    tbl[8] = mk(3'b010, 32'h007, 32'hAABBCCDD, 0, 1, 32'h004, 4'b1000, 32'hDD000000,
                32'h008, 4'b0111, 32'h00AABBCC);
`else
    tbl[6] = mk(3'b001, 32'h00F, 32'h00001234, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[7] = mk(3'b010, 32'h102, 32'h11223344, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[8] = mk(3'b010, 32'h007, 32'hAABBCCDD, 1, 0, 0, 0, 0, 0, 0, 0);
`endif

    RESET = 1'b1; MemWriteM = 1'b0; Funct3M = '0; AddrM = '0; WriteDataM = '0;
    mem.MemReady = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_req",   32'(mem.MemReq), 0);
    chk("rst_be",    32'(mem.MemByteEn), 0);
    chk("rst_addr",  mem.MemAddr, 0);
    chk("rst_wdata", mem.MemWData, 0);
    chk("rst_stall", 32'(StallM), 0);
    chk("rst_fault", 32'(MisalignFaultM), 0);

    for (int i = 0; i < 9; i++) begin
      v = tbl[i];
      @(negedge CLK);
      MemWriteM = 1'b1; Funct3M = v.f3; AddrM = v.addr; WriteDataM = v.data;
      mem.MemReady = 1'b1;
      #1;
      chk($sformatf("v%0d_stall_cap", i), 32'(StallM), 32'(!v.rej));
      chk($sformatf("v%0d_fault", i), 32'(MisalignFaultM), 32'(v.rej));
      @(negedge CLK);
      MemWriteM = 1'b0;
      #1;
      if (v.rej) begin
        chk($sformatf("v%0d_rej_req", i), 32'(mem.MemReq), 0);
        chk($sformatf("v%0d_rej_fault", i), 32'(MisalignFaultM), 0);
      end else begin
        chk($sformatf("v%0d_lo_req", i), 32'(mem.MemReq), 1);
        chk($sformatf("v%0d_lo_addr", i), mem.MemAddr, v.lo_a);
        chk($sformatf("v%0d_lo_be", i), 32'(mem.MemByteEn), 32'(v.lo_be));
        chk($sformatf("v%0d_lo_data", i), mem.MemWData, v.lo_d);
        chk($sformatf("v%0d_lo_stall", i), 32'(StallM), 32'(v.split));
        if (v.split) begin
          @(negedge CLK); #1;
          chk($sformatf("v%0d_hi_req", i), 32'(mem.MemReq), 1);
          chk($sformatf("v%0d_hi_addr", i), mem.MemAddr, v.hi_a);
          chk($sformatf("v%0d_hi_be", i), 32'(mem.MemByteEn), 32'(v.hi_be));
          chk($sformatf("v%0d_hi_data", i), mem.MemWData, v.hi_d);
          chk($sformatf("v%0d_hi_stall", i), 32'(StallM), 0);
        end
      end
      @(negedge CLK); #1;
      chk($sformatf("v%0d_idle_req", i), 32'(mem.MemReq), 0);
      chk($sformatf("v%0d_idle_be", i), 32'(mem.MemByteEn), 0);
    end

    // Wait in LO with MemReady low: outputs held, stall asserted.
    @(negedge CLK);
`ifdef MISALIGNED_SPLIT_EN
    MemWriteM = 1'b1; Funct3M = 3'b010; AddrM = 32'hFFFFFFFE; WriteDataM = 32'hA1B2C3D4;
`else
    MemWriteM = 1'b1; Funct3M = 3'b010; AddrM = 32'hFFFFFFFC; WriteDataM = 32'hA1B2C3D4;
`endif
    mem.MemReady = 1'b0;
    @(negedge CLK);
    MemWriteM = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("wait%0d_req", k), 32'(mem.MemReq), 1);
      chk($sformatf("wait%0d_addr", k), mem.MemAddr, 32'hFFFFFFFC);
`ifdef MISALIGNED_SPLIT_EN
      chk($sformatf("wait%0d_be", k), 32'(mem.MemByteEn), 32'(4'b1100));
      chk($sformatf("wait%0d_data", k), mem.MemWData, 32'hC3D40000);
`else
      chk($sformatf("wait%0d_be", k), 32'(mem.MemByteEn), 32'(4'b1111));
      chk($sformatf("wait%0d_data", k), mem.MemWData, 32'hA1B2C3D4);
`endif
      chk($sformatf("wait%0d_stall", k), 32'(StallM), 1);
      @(negedge CLK);
    end
    mem.MemReady = 1'b1;
    #1;
`ifdef MISALIGNED_SPLIT_EN
    chk("wait_acc_lo_stall", 32'(StallM), 1);
    @(negedge CLK); #1;
    chk("wrap_hi_req", 32'(mem.MemReq), 1);
    chk("wrap_hi_addr", mem.MemAddr, 32'h00000000);
    chk("wrap_hi_be", 32'(mem.MemByteEn), 32'(4'b0011));
    chk("wrap_hi_data", mem.MemWData, 32'h0000A1B2);
    chk("wrap_hi_stall", 32'(StallM), 0);
`else
    chk("wait_acc_stall", 32'(StallM), 0);
`endif
    @(negedge CLK); #1;
    chk("wait_done_req", 32'(mem.MemReq), 0);

    // Reset during the LO wait aborts the store; no HI access follows.
    @(negedge CLK);
`ifdef MISALIGNED_SPLIT_EN
    MemWriteM = 1'b1; Funct3M = 3'b001; AddrM = 32'h0000000F; WriteDataM = 32'h00001234;
`else
    MemWriteM = 1'b1; Funct3M = 3'b010; AddrM = 32'h00000100; WriteDataM = 32'h55AA55AA;
`endif
    mem.MemReady = 1'b0;
    @(negedge CLK);
    MemWriteM = 1'b0;
    #1;
    chk("rstlo_req_before", 32'(mem.MemReq), 1);
    @(negedge CLK);
    RESET = 1'b1; mem.MemReady = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rstlo_req", 32'(mem.MemReq), 0);
    chk("rstlo_be", 32'(mem.MemByteEn), 0);
    chk("rstlo_addr", mem.MemAddr, 0);
    chk("rstlo_stall", 32'(StallM), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK); #1;
      chk($sformatf("rstlo_nohi%0d", k), 32'(mem.MemReq), 0);
    end

    // Back-to-back: second store arrives the cycle after final acceptance.
    @(negedge CLK);
    MemWriteM = 1'b1; Funct3M = 3'b010; AddrM = 32'h00000400; WriteDataM = 32'h01020304;
    mem.MemReady = 1'b1;
    @(negedge CLK); #1;
    chk("b2b_a_req", 32'(mem.MemReq), 1);
    chk("b2b_a_stall", 32'(StallM), 0);
    @(negedge CLK);
    Funct3M = 3'b000; AddrM = 32'h00000502; WriteDataM = 32'h000000EE;
    #1;
    chk("b2b_gap_req", 32'(mem.MemReq), 0);
    chk("b2b_gap_stall", 32'(StallM), 1);
    @(negedge CLK);
    MemWriteM = 1'b0;
    #1;
    chk("b2b_b_req", 32'(mem.MemReq), 1);
    chk("b2b_b_addr", mem.MemAddr, 32'h00000500);
    chk("b2b_b_be", 32'(mem.MemByteEn), 32'(4'b0100));
    chk("b2b_b_data", mem.MemWData, 32'h00EE0000);
    @(negedge CLK); #1;
    chk("b2b_end_req", 32'(mem.MemReq), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
